// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module   : dmem_responder
// Brief    : Data-memory responder with fixed programmable latency, one
//            outstanding load/store. Optional macro DMEM_ALIGN_CHECK_EN flags
//            misaligned requests and empty-enable stores as errors.
// Revision : 1.0  initial release
// ============================================================================
module dmem_responder #(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
);

    localparam int         AW        = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE    = 2'd0;
    localparam logic [1:0] S_WAIT    = 2'd1;
    localparam logic [1:0] S_RESP    = 2'd2;
    localparam logic [3:0] c_lat_m1  = 4'(LATENCY - 1);
    localparam bit         c_lat_one = (LATENCY == 1);

    logic [1:0]    r_state;
    logic [3:0]    r_cnt;
    logic          r_write;
    logic [AW+1:0] r_addr;
    logic [31:0]   r_wdata;
    logic [3:0]    r_be;
    logic          r_req_ready;
    logic          r_resp_valid;
    logic [31:0]   r_resp_rdata;
    logic          r_resp_err;
    logic [31:0]   r_mem [DEPTH_WORDS];

    logic          w_accept;
    logic          w_go_resp;
    logic          w_acc_write;
    logic [AW+1:0] w_acc_addr;
    logic [31:0]   w_acc_wdata;
    logic [3:0]    w_acc_be;
    logic [AW-1:0] w_idx;
    logic          w_err;
    logic          w_we;
    logic          w_unused;

    assign w_accept  = (r_state == S_IDLE) && req_valid && r_req_ready;
    assign w_go_resp = (w_accept && c_lat_one) || ((r_state == S_WAIT) && (r_cnt == 4'd1));

    // With LATENCY==1 the access happens on the accept edge, so the live
    // request fields are used instead of the latched copies.
    assign w_acc_write = (r_state == S_IDLE) ? req_write           : r_write;
    assign w_acc_addr  = (r_state == S_IDLE) ? req_addr[AW+1:0]    : r_addr;
    assign w_acc_wdata = (r_state == S_IDLE) ? req_wdata           : r_wdata;
    assign w_acc_be    = (r_state == S_IDLE) ? req_be              : r_be;
    assign w_idx       = w_acc_addr[AW+1:2];

`ifdef DMEM_ALIGN_CHECK_EN
    assign w_err = (w_acc_addr[1:0] != 2'b00) || (w_acc_write && (w_acc_be == 4'b0000));
`else
    assign w_err = 1'b0;
`endif

    assign w_we     = w_go_resp && w_acc_write && !w_err && !reset;
    assign w_unused = &{1'b0, req_addr[31:AW+2], w_acc_addr[1:0]};

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= 4'd0;
            r_write      <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= 32'd0;
            r_be         <= 4'd0;
            r_req_ready  <= 1'b1;
            r_resp_valid <= 1'b0;
            r_resp_rdata <= 32'd0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_write     <= req_write;
                        r_addr      <= req_addr[AW+1:0];
                        r_wdata     <= req_wdata;
                        r_be        <= req_be;
                        r_cnt       <= c_lat_m1;
                        r_req_ready <= 1'b0;
                        r_state     <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - 4'd1;
                end
                S_RESP: begin
                    if (r_resp_valid && resp_ready) begin
                        r_resp_valid <= 1'b0;
                        r_resp_err   <= 1'b0;
                        r_req_ready  <= 1'b1;
                        r_state      <= S_IDLE;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    r_req_ready <= 1'b1;
                end
            endcase

            if (w_go_resp) begin
                r_state      <= S_RESP;
                r_resp_valid <= 1'b1;
                r_resp_rdata <= (w_acc_write || w_err) ? 32'd0 : r_mem[w_idx];
                r_resp_err   <= w_err;
            end
        end
    end

    // RAM is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (w_we) begin
            for (int i = 0; i < 4; i++) begin
                if (w_acc_be[i]) begin
                    r_mem[w_idx][8*i +: 8] <= w_acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign req_ready  = r_req_ready;
    assign resp_valid = r_resp_valid;
    assign resp_rdata = r_resp_rdata;
    assign resp_err   = r_resp_err;

endmodule
`default_nettype wire
